// File: rtl/dadda_acc_if.sv
// Handshake bundle between the Dadda product stream, the accumulator and the
// downstream consumer of group sums.
interface dadda_acc_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic [15:0]      prod_i;
    logic             prod_valid_i;
    logic             prod_last_i;
    logic             prod_ready_o;
    logic             clear_i;
    logic [ACC_W-1:0] sum_o;
    logic [CNT_W-1:0] sum_count_o;
    logic             sum_ovf_o;
    logic             sum_valid_o;
    logic             sum_ready_i;

    // The accumulator side.
    modport slave (
        input  prod_i, prod_valid_i, prod_last_i, clear_i, sum_ready_i,
        output prod_ready_o, sum_o, sum_count_o, sum_ovf_o, sum_valid_o
    );

    // The side that feeds products and drains results.
    modport master (
        output prod_i, prod_valid_i, prod_last_i, clear_i, sum_ready_i,
        input  prod_ready_o, sum_o, sum_count_o, sum_ovf_o, sum_valid_o
    );
endinterface

// File: rtl/dadda_acc.sv
// Streaming group accumulator for 16-bit multiplier products: sums beats up to
// a last flag and presents a registered sum, saturating count and overflow flag.
module dadda_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    dadda_acc_if.slave bus
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] sum_cnt_q, sum_cnt_d;
    logic             sum_ovf_q, sum_ovf_d;
    logic             sum_valid_q, sum_valid_d;

    logic             ready;
    logic             accept;
    logic [ACC_W:0]   add_full;
    logic [CNT_W-1:0] cnt_inc;

    // Ready looks at the downstream ready combinationally so a drain and a new
    // last beat can share one edge.
    assign ready    = rst_n & ~bus.clear_i & (~sum_valid_q | bus.sum_ready_i);
    assign accept   = bus.prod_valid_i & ready;
    assign add_full = {1'b0, acc_q} + (ACC_W+1)'(bus.prod_i);
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        sum_cnt_d   = sum_cnt_q;
        sum_ovf_d   = sum_ovf_q;
        sum_valid_d = sum_valid_q;

        if (sum_valid_q && bus.sum_ready_i)
            sum_valid_d = 1'b0;

        if (bus.clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            if (bus.prod_last_i) begin
                sum_d       = add_full[ACC_W-1:0];
                sum_ovf_d   = ovf_q | add_full[ACC_W];
                sum_cnt_d   = cnt_inc;
                sum_valid_d = 1'b1;
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                state_d = ACCUM;
                acc_d   = add_full[ACC_W-1:0];
                ovf_d   = ovf_q | add_full[ACC_W];
                cnt_d   = cnt_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            sum_cnt_q   <= '0;
            sum_ovf_q   <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            sum_cnt_q   <= sum_cnt_d;
            sum_ovf_q   <= sum_ovf_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.prod_ready_o = ready;
    assign bus.sum_o        = sum_q;
    assign bus.sum_count_o  = sum_cnt_q;
    assign bus.sum_ovf_o    = sum_ovf_q;
    assign bus.sum_valid_o  = sum_valid_q;

endmodule

// File: tb/tb_dadda_acc.sv
// Directed self-checking bench for dadda_acc: single and multi-beat groups,
// overflow/saturation, backpressure, clear and mid-group reset.
module tb_dadda_acc;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dadda_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    dadda_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs read here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [15:0] p, input logic v, input logic l);
        bus.prod_i       = p;
        bus.prod_valid_i = v;
        bus.prod_last_i  = l;
    endtask

    task automatic check_out(input string tag, input logic [31:0] s, input logic [31:0] c,
                             input logic [31:0] o, input logic [31:0] v);
        check({tag, ".sum"},   32'(bus.sum_o),       s);
        check({tag, ".count"}, 32'(bus.sum_count_o), c);
        check({tag, ".ovf"},   32'(bus.sum_ovf_o),   o);
        check({tag, ".valid"}, 32'(bus.sum_valid_o), v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(16'h0, 1'b0, 1'b0);
        bus.clear_i     = 1'b0;
        bus.sum_ready_i = 1'b1;

        // Reset state
        step();
        step();
        check_out("reset", 0, 0, 0, 0);
        check("reset.ready", 32'(bus.prod_ready_o), 0);
        rst_n = 1'b1;
        #1;
        check("release.ready", 32'(bus.prod_ready_o), 1);

        // 1: single-beat group
        drive(16'hFFFF, 1'b1, 1'b1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        check_out("single", 32'h00FFFF, 1, 0, 1);
        step();
        check("single.drain", 32'(bus.sum_valid_o), 0);

        // 2: multi-beat group then immediate single-beat group
        drive(16'd10, 1'b1, 1'b0);
        step();
        check("multi.no_early_valid", 32'(bus.sum_valid_o), 0);
        drive(16'd20, 1'b1, 1'b0);
        step();
        drive(16'd30, 1'b1, 1'b0);
        step();
        drive(16'd40, 1'b1, 1'b1);
        step();
        check_out("multi", 100, 4, 0, 1);
        drive(16'd5, 1'b1, 1'b1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        check_out("b2b", 5, 1, 0, 1);
        step();
        check("b2b.drain", 32'(bus.sum_valid_o), 0);

        // 3: overflow and count saturation over 257 beats
        for (int i = 0; i < 256; i++) begin
            drive(16'hFFFF, 1'b1, 1'b0);
            step();
        end
        check("sat.no_early_valid", 32'(bus.sum_valid_o), 0);
        drive(16'hFFFF, 1'b1, 1'b1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        check_out("sat", 32'h00FEFF, 255, 1, 1);
        step();

        // 4: backpressure
        bus.sum_ready_i = 1'b0;
        drive(16'd3, 1'b1, 1'b0);
        step();
        drive(16'd4, 1'b1, 1'b1);
        step();
        check_out("bp.first", 7, 2, 0, 1);
        drive(16'd7, 1'b1, 1'b1);
        #1;
        check("bp.ready_low", 32'(bus.prod_ready_o), 0);
        step();
        check_out("bp.hold1", 7, 2, 0, 1);
        step();
        check_out("bp.hold2", 7, 2, 0, 1);
        bus.sum_ready_i = 1'b1;
        #1;
        check("bp.ready_high", 32'(bus.prod_ready_o), 1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        bus.sum_ready_i = 1'b0;
        check_out("bp.second", 7, 1, 0, 1);
        step();
        check_out("bp.second_hold", 7, 1, 0, 1);
        bus.sum_ready_i = 1'b1;
        step();
        check("bp.drain", 32'(bus.sum_valid_o), 0);

        // 5: clear mid-group
        drive(16'd9, 1'b1, 1'b0);
        step();
        step();
        drive(16'd100, 1'b1, 1'b0);
        bus.clear_i = 1'b1;
        #1;
        check("clr.ready", 32'(bus.prod_ready_o), 0);
        step();
        bus.clear_i = 1'b0;
        drive(16'd6, 1'b1, 1'b1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        check_out("clr", 6, 1, 0, 1);
        step();

        // 6: reset mid-group
        drive(16'd50, 1'b1, 1'b0);
        step();
        drive(16'd60, 1'b1, 1'b0);
        step();
        drive(16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        check_out("rst.mid1", 0, 0, 0, 0);
        check("rst.ready", 32'(bus.prod_ready_o), 0);
        step();
        check_out("rst.mid2", 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(16'd8, 1'b1, 1'b1);
        step();
        drive(16'h0, 1'b0, 1'b0);
        check_out("rst.after", 8, 1, 0, 1);
        step();
        check("rst.drain", 32'(bus.sum_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dadda_acc.md
# dadda_acc

Streaming accumulator that sits directly downstream of the 8x8 unsigned Dadda multiplier (`dadda_gate`). It consumes the multiplier's 16-bit product one beat per cycle over a valid/ready handshake. It sums products into a group terminated by a `last` flag, and presents the registered group sum, beat count and overflow flag on an output valid/ready handshake. Typical use is a dot-product / FIR-tap stage.

## Interface
- `ACC_W`, default 24: accumulator and sum width in bits; must be ≥16.
- `CNT_W`, default 8: beat-count width in bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `prod_i` input 16: unsigned product (multiplier `f[15:0]`).
- `prod_valid_i` input 1: `prod_i` / `prod_last_i` are valid.
- `prod_last_i` input 1: the beat is the final beat of the current group.
- `prod_ready_o` output 1: the block accepts a beat this cycle.
- `clear_i` input 1: synchronous abort of the group in progress.
- `sum_o` output ACC_W: group sum, modulo 2^ACC_W.
- `sum_count_o` output CNT_W: number of beats in the group, saturating.
- `sum_ovf_o` output 1: the group sum exceeded 2^ACC_W−1 at any point.
- `sum_valid_o` output 1: the `sum_*` outputs hold a result.
- `sum_ready_i` input 1: downstream takes the result.

## Operation
- **Beat acceptance.** A beat is accepted on an edge where `prod_valid_i & prod_ready_o`.
- **Ready.** `prod_ready_o = rst_n & ~clear_i & (~sum_valid_o | sum_ready_i)`. This is a combinational path from `sum_ready_i`.
- **Group state.** The working state is `acc` (ACC_W), `cnt` (CNT_W) and `ovf` (1).
- **FSM states.**
  - IDLE: no beats held; `acc`=0, `cnt`=0, `ovf`=0.
  - ACCUM: ≥1 non-last beat held.
- **Non-last beat accepted.**
  - `acc <= acc + zext(prod_i)`, wrapping.
  - `ovf <= ovf | carry-out`.
  - `cnt <= min(cnt+1, 2^CNT_W−1)`.
  - State goes to ACCUM.
- **Last beat accepted (from IDLE or ACCUM).**
  - The output register loads `sum_o`=acc+prod (wrapped), `sum_ovf_o`=ovf|carry, `sum_count_o`=sat(cnt+1).
  - `sum_valid_o <= 1`.
  - `acc`, `cnt` and `ovf` clear; state goes to IDLE.
- **Output drain.** `sum_valid_o & sum_ready_i` with no new last beat gives `sum_valid_o <= 0`. The `sum_*` data holds its last value.
- **Simultaneous drain and last beat.** The new result loads and `sum_valid_o` stays 1, so back-to-back results are possible.
- **Output stability.** While `sum_valid_o=1` and `sum_ready_i=0`, all `sum_*` outputs are stable and no beat is accepted.
- **Clear.** `clear_i=1` clears `acc`, `cnt` and `ovf` and sets state to IDLE.
  - A beat presented that cycle is not accepted, because ready is 0.
  - A pending output result is unaffected and still drains normally.
- **Arithmetic.** All arithmetic is unsigned. The product is zero-extended to ACC_W; carry is detected on an ACC_W+1-bit add.

## Timing
- **Reset.** With `rst_n`=0 at an edge:
  - `sum_o`=0, `sum_count_o`=0, `sum_ovf_o`=0, `sum_valid_o`=0.
  - State is IDLE; `acc`, `cnt` and `ovf` are 0.
  - `prod_ready_o`=0 while `rst_n` is low, and 1 in the first cycle after release.
- **Latency.** A last beat accepted at edge k gives `sum_valid_o`=1 in the cycle after edge k (1-cycle latency).
- **Throughput.** One beat per cycle sustained while `sum_ready_i`=1, including consecutive single-beat groups.
- **Reset mid-group or mid-hold.** Any accumulated beats and any pending result are discarded; no `sum_valid_o` pulse is produced.
- **Count saturation.** `sum_count_o` sticks at 2^CNT_W−1. The sum continues to accumulate; saturation does not set `sum_ovf_o`.

## Test plan
1. **Single-beat group.** After reset, `prod_i`=0xFFFF with valid and last, `sum_ready_i`=1.
   - Next cycle: `sum_o`=0x00FFFF, `sum_count_o`=1, `sum_ovf_o`=0, `sum_valid_o` high for 1 cycle.
2. **Multi-beat group.** Beats 10, 20, 30, 40 (last on 40) on consecutive cycles.
   - `sum_o`=100, `sum_count_o`=4.
   - An immediately following single beat 5 (last) gives `sum_o`=5, `sum_count_o`=1 on the next cycle.
3. **Overflow and count saturation.** 257 beats of 0xFFFF, last on the final beat.
   - `sum_o`=0x00FEFF (16,842,495 mod 2^24), `sum_ovf_o`=1, `sum_count_o`=255.
4. **Backpressure.** `sum_ready_i`=0; group {3, 4 last}, then group {7 last} presented.
   - `sum_o`=7 holds stable; `prod_ready_o`=0 with the second group pending.
   - After `sum_ready_i`=1 for 1 cycle, the second group is accepted and `sum_o`=7, count 1; no beat is lost.
5. **Clear mid-group.** Beats 9, 9, then `clear_i`=1 for 1 cycle with a beat 100 presented (must not be accepted), then 6 (last).
   - `sum_o`=6, `sum_count_o`=1, `sum_ovf_o`=0.
6. **Reset mid-operation.** Beats 50, 60 accepted, then `rst_n`=0 for 2 cycles, then 8 (last).
   - Only `sum_o`=8, `sum_count_o`=1 is produced; all outputs read 0 during reset.
